// File: rtl/ps2_attack_receiver_if.sv
// Bundles the PS/2 line pair and the attack-command outputs of the receiver.
// master: the receiver itself; slave: the keyboard side plus downstream consumer.
interface ps2_attack_receiver_if;
  logic       clk_kb;
  logic       data_kb;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic [3:0] attack;
  logic       attack_valid;
  logic       frame_err;

  modport master (
    input  clk_kb, data_kb,
    output scan_code, scan_valid, attack, attack_valid, frame_err
  );

  modport slave (
    output clk_kb, data_kb,
    input  scan_code, scan_valid, attack, attack_valid, frame_err
  );
endinterface

// File: rtl/ps2_attack_receiver.sv
// PS/2 keyboard front end for the combat stage: oversamples the keyboard
// lines on the system clock, assembles 11-bit frames, tracks break/extended
// prefixes, suppresses typematic repeats and emits one-cycle attack strobes.
module ps2_attack_receiver #(
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] LIGHT_CODE     = 8'h1C,
  parameter logic [7:0] HEAVY_CODE     = 8'h23,
  parameter logic [7:0] STANDBY_CODE   = 8'h29
) (
  input logic                   clk,
  input logic                   reset,
  ps2_attack_receiver_if.master bus
);

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX   = 8'hE0;

  localparam logic [3:0] ATK_NONE    = 4'b0000;
  localparam logic [3:0] ATK_LIGHT   = 4'b0001;
  localparam logic [3:0] ATK_HEAVY   = 4'b0010;
  localparam logic [3:0] ATK_STANDBY = 4'b0011;

  localparam int             TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } state_t;

  // Synchronizers plus one history flop for the keyboard clock.
  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [8:0]    shift_reg;   // {parity, data[7:0]} once all nine bits are in
  logic [TW-1:0] to_cnt;

  logic          break_pending;
  logic          ext_pending;
  logic [7:0]    held_code;
  logic          held_valid;

  logic          fall;
  logic          data_bit;
  logic [7:0]    rx_byte;
  logic          frame_good;

  assign fall       = clk_prev & ~clk_s2;
  assign data_bit   = data_s2;
  assign rx_byte    = shift_reg[7:0];
  assign frame_good = data_bit & (^shift_reg);

  // Maps a plain make code to its attack command, ATK_NONE if not an attack key.
  function automatic logic [3:0] attack_for(input logic [7:0] code);
    if (code == LIGHT_CODE)        return ATK_LIGHT;
    else if (code == HEAVY_CODE)   return ATK_HEAVY;
    else if (code == STANDBY_CODE) return ATK_STANDBY;
    else                           return ATK_NONE;
  endfunction

  // Two-flop synchronizers for both keyboard lines, plus clock history for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: synchronizers reset to 1, the idle level of the open-collector PS/2 lines,
      // so release of reset can never look like a falling edge.
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop sample the previous stage's old value,
      // which is what builds a real two-stage chain.
      clk_s1   <= bus.clk_kb;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= bus.data_kb;
      data_s2  <= data_s1;
    end
  end

  // Frame FSM, timeout, byte decode and registered output strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      bit_cnt          <= '0;
      shift_reg        <= '0;
      to_cnt           <= '0;
      break_pending    <= 1'b0;
      ext_pending      <= 1'b0;
      held_code        <= '0;
      held_valid       <= 1'b0;
      bus.scan_code    <= '0;
      bus.scan_valid   <= 1'b0;
      bus.attack       <= ATK_NONE;
      bus.attack_valid <= 1'b0;
      bus.frame_err    <= 1'b0;
    end else begin
      bus.scan_valid   <= 1'b0;
      bus.attack_valid <= 1'b0;
      bus.frame_err    <= 1'b0;

      if (state != IDLE && to_cnt == TO_LAST) begin
        // Keyboard stalled mid-frame: abort. Takes priority over a coincident fall.
        state         <= IDLE;
        bit_cnt       <= '0;
        to_cnt        <= '0;
        bus.frame_err <= 1'b1;
      end else begin
        if (fall || state == IDLE) to_cnt <= '0;
        else                       to_cnt <= to_cnt + 1'b1;

        case (state)
          IDLE: begin
            if (fall) begin
              if (!data_bit) begin
                state   <= SHIFT;
                bit_cnt <= '0;
              end else begin
                bus.frame_err <= 1'b1;
              end
            end
          end

          SHIFT: begin
            if (fall) begin
              // LSB arrives first, so shifting in from the top leaves bit 0 at shift_reg[0].
              shift_reg <= {data_bit, shift_reg[8:1]};
              if (bit_cnt == 4'd8) state <= STOP;
              else                 bit_cnt <= bit_cnt + 1'b1;
            end
          end

          STOP: begin
            if (fall) begin
              state   <= IDLE;
              bit_cnt <= '0;
              if (!frame_good) begin
                bus.frame_err <= 1'b1;
              end else begin
                bus.scan_code  <= rx_byte;
                bus.scan_valid <= 1'b1;
                if (rx_byte == BREAK_PREFIX) begin
                  break_pending <= 1'b1;
                end else if (rx_byte == EXT_PREFIX) begin
                  ext_pending <= 1'b1;
                end else if (break_pending) begin
                  break_pending <= 1'b0;
                  ext_pending   <= 1'b0;
                  if (rx_byte == held_code) held_valid <= 1'b0;
                end else if (ext_pending) begin
                  ext_pending <= 1'b0;
                end else if (held_valid && rx_byte == held_code) begin
                  // Typematic repeat of the key already held: swallowed.
                end else if (attack_for(rx_byte) != ATK_NONE) begin
                  bus.attack       <= attack_for(rx_byte);
                  bus.attack_valid <= 1'b1;
                  held_code        <= rx_byte;
                  held_valid       <= 1'b1;
                end
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_attack_receiver.sv
// Self-checking bench for ps2_attack_receiver: drives PS/2 frames, pushes
// expected scan codes and attacks into queues, and a monitor pops and
// compares them as the DUT strobes its outputs.
module tb_ps2_attack_receiver;

  localparam int TIMEOUT = 300;
  localparam int HALF    = 20;   // system clocks per PS/2 clock half period

  logic clk;
  logic reset;

  ps2_attack_receiver_if bus ();

  ps2_attack_receiver #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .LIGHT_CODE    (8'h1C),
    .HEAVY_CODE    (8'h23),
    .STANDBY_CODE  (8'h29)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] exp_scan[$];
  logic [3:0] exp_atk[$];

  int  scan_pulses = 0;
  int  atk_pulses  = 0;
  int  err_pulses  = 0;
  bit  prev_sv = 1'b0;
  bit  prev_av = 1'b0;
  bit  prev_fe = 1'b0;

  // Scoreboard monitor: compares every strobe against the queued expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.scan_valid) begin
        scan_pulses++;
        tests_run++;
        if (exp_scan.size() == 0) begin
          tests_failed++;
          $display("FAIL scan_unexpected: got scan_code=%h, none expected", bus.scan_code);
        end else begin
          logic [7:0] e;
          e = exp_scan.pop_front();
          if (bus.scan_code !== e) begin
            tests_failed++;
            $display("FAIL scan_code: got %h, expected %h", bus.scan_code, e);
          end
        end
        if (prev_sv) begin
          tests_failed++;
          $display("FAIL scan_valid_width: got 2+ cycles, expected 1");
        end
      end
      if (bus.attack_valid) begin
        atk_pulses++;
        tests_run++;
        if (exp_atk.size() == 0) begin
          tests_failed++;
          $display("FAIL attack_unexpected: got attack=%b, none expected", bus.attack);
        end else begin
          logic [3:0] a;
          a = exp_atk.pop_front();
          if (bus.attack !== a) begin
            tests_failed++;
            $display("FAIL attack: got %b, expected %b", bus.attack, a);
          end
        end
        if (prev_av) begin
          tests_failed++;
          $display("FAIL attack_valid_width: got 2+ cycles, expected 1");
        end
      end
      if (bus.frame_err) begin
        err_pulses++;
        if (prev_fe) begin
          tests_run++;
          tests_failed++;
          $display("FAIL frame_err_width: got 2+ cycles, expected 1");
        end
      end
    end
    prev_sv = bus.scan_valid;
    prev_av = bus.attack_valid;
    prev_fe = bus.frame_err;
  end

  task automatic apply_reset();
    reset       = 1'b0;
    bus.clk_kb  = 1'b1;
    bus.data_kb = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  // Sends the first nbits of a frame (11 = complete): start, 8 data LSB first, odd parity, stop.
  task automatic send_frame(input logic [7:0] b, input bit bad_parity, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      #1 bus.data_kb = fr[i];
      repeat (HALF) @(posedge clk);
      #1 bus.clk_kb = 1'b0;
      repeat (HALF) @(posedge clk);
      #1 bus.clk_kb = 1'b1;
    end
    repeat (HALF) @(posedge clk);
    #1 bus.data_kb = 1'b1;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    tests_run++;
    if (bus.scan_code !== 8'h00 || bus.scan_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_scan: got scan_code=%h scan_valid=%b, expected 00/0", bus.scan_code, bus.scan_valid);
    end
    tests_run++;
    if (bus.attack !== 4'b0000 || bus.attack_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_attack: got attack=%b av=%b fe=%b, expected 0000/0/0",
               bus.attack, bus.attack_valid, bus.frame_err);
    end
  endtask

  task automatic test_single_light();
    int e0, a0;
    e0 = err_pulses; a0 = atk_pulses;
    exp_scan.push_back(8'h1C); exp_atk.push_back(4'b0001);
    send_frame(8'h1C, 1'b0, 11);
    tests_run++;
    if (atk_pulses - a0 !== 1 || err_pulses - e0 !== 0) begin
      tests_failed++;
      $display("FAIL single_light: got attack pulses=%0d errs=%0d, expected 1/0", atk_pulses - a0, err_pulses - e0);
    end
    tests_run++;
    if (bus.attack !== 4'b0001 || bus.scan_code !== 8'h1C) begin
      tests_failed++;
      $display("FAIL single_light_held: got attack=%b scan=%h, expected 0001/1C", bus.attack, bus.scan_code);
    end
  endtask

  task automatic test_typematic();
    int s0, a0;
    logic [7:0] seq [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
    apply_reset();
    s0 = scan_pulses; a0 = atk_pulses;
    foreach (seq[i]) exp_scan.push_back(seq[i]);
    exp_atk.push_back(4'b0001);
    exp_atk.push_back(4'b0001);
    foreach (seq[i]) send_frame(seq[i], 1'b0, 11);
    tests_run++;
    if (scan_pulses - s0 !== 6 || atk_pulses - a0 !== 2) begin
      tests_failed++;
      $display("FAIL typematic: got scan=%0d attack=%0d pulses, expected 6/2", scan_pulses - s0, atk_pulses - a0);
    end
  endtask

  task automatic test_parity_err();
    int s0, e0;
    s0 = scan_pulses; e0 = err_pulses;
    send_frame(8'h23, 1'b1, 11);
    tests_run++;
    if (err_pulses - e0 !== 1 || scan_pulses - s0 !== 0) begin
      tests_failed++;
      $display("FAIL parity_err: got errs=%0d scans=%0d, expected 1/0", err_pulses - e0, scan_pulses - s0);
    end
    tests_run++;
    if (bus.attack !== 4'b0001) begin
      tests_failed++;
      $display("FAIL parity_attack_hold: got %b, expected 0001", bus.attack);
    end
    exp_scan.push_back(8'h23); exp_atk.push_back(4'b0010);
    send_frame(8'h23, 1'b0, 11);
    tests_run++;
    if (bus.attack !== 4'b0010) begin
      tests_failed++;
      $display("FAIL parity_recover: got %b, expected 0010", bus.attack);
    end
  endtask

  task automatic test_timeout();
    int e0, s0;
    e0 = err_pulses; s0 = scan_pulses;
    send_frame(8'h55, 1'b0, 5);
    repeat (TIMEOUT + 20) @(posedge clk);
    tests_run++;
    if (err_pulses - e0 !== 1 || scan_pulses - s0 !== 0) begin
      tests_failed++;
      $display("FAIL timeout: got errs=%0d scans=%0d, expected 1/0", err_pulses - e0, scan_pulses - s0);
    end
    exp_scan.push_back(8'h29); exp_atk.push_back(4'b0011);
    send_frame(8'h29, 1'b0, 11);
    tests_run++;
    if (bus.attack !== 4'b0011 || err_pulses - e0 !== 1) begin
      tests_failed++;
      $display("FAIL timeout_recover: got attack=%b errs=%0d, expected 0011/1", bus.attack, err_pulses - e0);
    end
  endtask

  task automatic test_extended();
    int s0, a0;
    s0 = scan_pulses; a0 = atk_pulses;
    exp_scan.push_back(8'hE0); exp_scan.push_back(8'h1C);
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 11);
    tests_run++;
    if (scan_pulses - s0 !== 2 || atk_pulses - a0 !== 0) begin
      tests_failed++;
      $display("FAIL extended: got scans=%0d attacks=%0d, expected 2/0", scan_pulses - s0, atk_pulses - a0);
    end
    exp_scan.push_back(8'h1C); exp_atk.push_back(4'b0001);
    send_frame(8'h1C, 1'b0, 11);
    tests_run++;
    if (atk_pulses - a0 !== 1 || bus.attack !== 4'b0001) begin
      tests_failed++;
      $display("FAIL extended_after: got attacks=%0d attack=%b, expected 1/0001", atk_pulses - a0, bus.attack);
    end
  endtask

  task automatic test_reset_midframe();
    int s0, e0;
    send_frame(8'h23, 1'b0, 5);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.scan_code !== 8'h00 || bus.attack !== 4'b0000 || bus.scan_valid !== 1'b0 ||
        bus.attack_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL midframe_reset_outputs: got scan=%h attack=%b sv=%b av=%b fe=%b, expected all 0",
               bus.scan_code, bus.attack, bus.scan_valid, bus.attack_valid, bus.frame_err);
    end
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    s0 = scan_pulses; e0 = err_pulses;
    exp_scan.push_back(8'h23); exp_atk.push_back(4'b0010);
    send_frame(8'h23, 1'b0, 11);
    tests_run++;
    if (scan_pulses - s0 !== 1 || err_pulses - e0 !== 0 || bus.attack !== 4'b0010) begin
      tests_failed++;
      $display("FAIL midframe_recover: got scans=%0d errs=%0d attack=%b, expected 1/0/0010",
               scan_pulses - s0, err_pulses - e0, bus.attack);
    end
  endtask

  initial begin
    reset       = 1'b0;
    bus.clk_kb  = 1'b1;
    bus.data_kb = 1'b1;
    test_reset();
    test_single_light();
    test_typematic();
    test_parity_err();
    test_timeout();
    test_extended();
    test_reset_midframe();
    repeat (10) @(posedge clk);
    tests_run++;
    if (exp_scan.size() !== 0 || exp_atk.size() !== 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d scans and %0d attacks still pending, expected 0/0",
               exp_scan.size(), exp_atk.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ps2_attack_receiver.md
Name: ps2_attack_receiver

Overview:
Upstream front end for the combat/health stage. It oversamples the PS/2 keyboard lines on the system clock, assembles and checks 11-bit frames, tracks make/break/extended prefixes, and suppresses typematic repeats. It emits clean one-cycle attack command strobes (light, heavy, standby) that the downstream health logic consumes synchronously. This replaces clocking game logic directly from the keyboard clock.

Parameters:
TIMEOUT_CYCLES, 100000, system clocks of PS/2 clock inactivity mid-frame before abort (1 ms at 100 MHz)
LIGHT_CODE, 8'h1C, make code for light attack ("A")
HEAVY_CODE, 8'h23, make code for heavy attack ("D")
STANDBY_CODE, 8'h29, make code for standby (space)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
clk_kb  input  1  raw PS/2 clock, asynchronous
data_kb  input  1  raw PS/2 data, asynchronous
scan_code  output  8  last good received byte, held
scan_valid  output  1  one-cycle pulse per good byte, including F0/E0
attack  output  4  last command: 4'b0001 light, 4'b0010 heavy, 4'b0011 standby; held
attack_valid  output  1  one-cycle pulse when attack is updated
frame_err  output  1  one-cycle pulse on start, parity or stop error, or on timeout

Behaviour:
- Reset (reset=0, asynchronous):
  - scan_code=0, scan_valid=0, attack=4'b0000, attack_valid=0, frame_err=0.
  - Synchronizer flops=1, FSM=IDLE, bit counter=0, timeout counter=0.
  - break_pending=0, ext_pending=0, held_code=0, held_valid=0.
  - Reset asserted mid-frame discards the partial frame; no pulse is emitted.
- Synchronization: clk_kb and data_kb each pass through 2 flops. A fall event is a cycle where the previous synced clk_kb is 1 and the current one is 0. data is sampled from synced data_kb in that same cycle.
- FSM:
  - IDLE: on a fall event with data=0 (start), go to SHIFT with count=0. A fall event with data=1 pulses frame_err and stays in IDLE.
  - SHIFT: on each fall event, shift data into bit[count], LSB first, count+1. Bits 0-7 are data, bit 8 is parity. After parity go to STOP.
  - STOP: on the next fall event, evaluate the frame, then return to IDLE.
- Frame check, on the stop fall event:
  - The frame is good if stop=1 and XOR(data[7:0], parity)=1 (odd parity).
  - Good frame: scan_code and scan_valid update on the next cycle.
  - Bad frame: frame_err pulses instead; scan_code and the decode state are unchanged.
- Timeout:
  - The counter clears on every fall event and in IDLE, and increments otherwise.
  - In SHIFT or STOP, when it reaches TIMEOUT_CYCLES-1: go to IDLE and pulse frame_err.
  - A fall event in the same cycle as the timeout: timeout wins.
- Decode, same cycle as scan_valid, good bytes only:
  - 8'hF0: set break_pending. No attack.
  - 8'hE0: set ext_pending. No attack.
  - Any other byte with break_pending=1: it is a release. Clear both pending flags; if byte==held_code, clear held_valid. No attack.
  - Any other byte with ext_pending=1: clear ext_pending. No attack; extended keys are ignored.
  - Plain make byte equal to held_code with held_valid=1: typematic repeat, suppressed, no attack.
  - Plain make byte matching LIGHT/HEAVY/STANDBY_CODE: update attack, pulse attack_valid, set held_code=byte and held_valid=1.
  - Plain make byte matching none of the codes: no attack; held state unchanged.
- Latency: scan_valid and attack_valid are asserted in the cycle after the stop-bit fall event is detected, which is 3 clk cycles after the raw clk_kb falling edge. At most one pulse of each per frame.
- A new press of a different attack key while another key is held is accepted; held_code moves to the new key.

Test Plan:
1. Send frame 8'h1C (parity 0, stop 1) -> scan_valid for 1 cycle, scan_code=8'h1C, attack=4'b0001, attack_valid 1 cycle, frame_err=0.
2. Send 1C, 1C, 1C (typematic), then F0 1C, then 1C -> exactly 2 attack_valid pulses: the first and the last 1C. scan_valid pulses 6 times.
3. Send 8'h23 with a corrupted parity bit -> frame_err 1 cycle; no scan_valid; attack stays at its prior value; a following good 23 gives attack=4'b0010.
4. Stop clk_kb after 5 bits, for TIMEOUT_CYCLES clocks -> frame_err pulses once and FSM returns to IDLE; next good 8'h29 gives attack=4'b0011.
5. Send E0 1C -> scan_valid twice, no attack_valid; then send 1C -> attack_valid with attack=4'b0001.
6. Assert reset after bit 4 of a frame, release it, then send a full 8'h23 -> all outputs 0 during reset, no pulse for the aborted frame; 23 decodes to attack=4'b0010.
